// File: rtl/counter_pkg.sv
// Shared types for the counter experiment set: down-counter state encoding and
// the one-shot / auto-reload mode constants.
package counter_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} dcnt_state_t;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/negedge_loadable_down_counter_if.sv
// Control and status bundle of the loadable down counter; the master drives
// load/count controls and the counter (slave) returns count, terminal count and busy.
interface negedge_loadable_down_counter_if #(
   parameter int WIDTH = 3
);

   logic             load;
   logic [WIDTH-1:0] d;
   logic             en;
   logic             mode;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             busy;

   modport master (
      output load, d, en, mode,
      input  q, tc, busy
   );

   modport slave (
      input  load, d, en, mode,
      output q, tc, busy
   );

endinterface

// File: rtl/negedge_loadable_down_counter.sv
// Falling-edge loadable down counter: counts a loaded value to zero, flags terminal
// count for one cycle, then either stops (one-shot) or reloads (divide-by-(N+1)).
module negedge_loadable_down_counter
   import counter_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input logic                            clk,
   input logic                            rst,
   negedge_loadable_down_counter_if.slave bus
);

   dcnt_state_t      state, stateNext;
   logic [WIDTH-1:0] count, countNext;
   logic [WIDTH-1:0] reloadVal, reloadValNext;
   logic             tcReg, tcNext;

   // All state, including the registered terminal-count flag, moves on the falling edge
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         reloadVal <= '0;
         tcReg     <= 1'b0;
      end else begin
         state     <= stateNext;
         count     <= countNext;
         reloadVal <= reloadValNext;
         tcReg     <= tcNext;
      end
   end

   // Load beats counting; the zero decision edge is where MODE picks stop or reload
   always_comb begin
      stateNext     = state;
      countNext     = count;
      reloadValNext = reloadVal;
      tcNext        = 1'b0;
      if (bus.load) begin
         countNext     = bus.d;
         reloadValNext = bus.d;
         stateNext     = (bus.d != '0) ? RUN : DONE;
      end else begin
         unique case (state)
            RUN: begin
               if (bus.en) begin
                  if (count > WIDTH'(1)) begin
                     countNext = count - WIDTH'(1);
                  end else if (count == WIDTH'(1)) begin
                     countNext = '0;
                     tcNext    = 1'b1;
                  end else if (bus.mode == MODE_RELOAD) begin
                     countNext = reloadVal;
                  end else begin
                     stateNext = DONE;
                  end
               end
            end
            IDLE, DONE: begin
               stateNext = state;
            end
            default: begin
               stateNext = IDLE;
            end
         endcase
      end
   end

   always_comb begin
      bus.q    = count;
      bus.tc   = tcReg;
      bus.busy = (state == RUN);
   end

endmodule

// File: tb/tb_negedge_loadable_down_counter.sv
// Scoreboard bench for the falling-edge loadable down counter: a reference model
// predicts each edge, and the prediction is popped and compared after that edge.
module tb_negedge_loadable_down_counter;

   localparam int WIDTH = 3;

   typedef struct {
      logic [WIDTH-1:0] q;
      logic             tc;
      logic             busy;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   exp_t sbQueue[$];

   logic [WIDTH-1:0] mQ;
   logic [WIDTH-1:0] mRv;
   int               mState;
   logic             mTc;

   negedge_loadable_down_counter_if #(.WIDTH(WIDTH)) bus ();

   negedge_loadable_down_counter #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Model states: 0 idle, 1 run, 2 done
   task automatic modelReset();
      mQ = '0; mRv = '0; mState = 0; mTc = 1'b0;
   endtask

   task automatic modelEdge(input logic ld, input logic [WIDTH-1:0] dv, input logic ev, input logic mv);
      mTc = 1'b0;
      if (ld) begin
         mQ = dv; mRv = dv;
         mState = (dv != 0) ? 1 : 2;
      end else if (mState == 1 && ev) begin
         if (mQ == 0) begin
            if (mv) mQ = mRv;
            else mState = 2;
         end else begin
            mQ = mQ - 1'b1;
            mTc = (mQ == 0);
         end
      end
   endtask

   task automatic applyStimulus(input logic ld, input logic [WIDTH-1:0] dv, input logic ev, input logic mv);
      exp_t e;
      @(posedge clk);
      bus.load = ld; bus.d = dv; bus.en = ev; bus.mode = mv;
      modelEdge(ld, dv, ev, mv);
      e.q = mQ; e.tc = mTc; e.busy = (mState == 1);
      sbQueue.push_back(e);
   endtask

   task automatic checkOutput(input string name);
      exp_t e;
      @(negedge clk);
      #1;
      checks++;
      if (sbQueue.size() == 0) begin
         errors++;
         $display("[TB] FAIL %s: scoreboard empty, q=%0d", name, bus.q);
         return;
      end
      e = sbQueue.pop_front();
      if (bus.q !== e.q) begin
         errors++;
         $display("[TB] FAIL %s q: got %0d expected %0d", name, bus.q, e.q);
      end
      checks++;
      if (bus.tc !== e.tc) begin
         errors++;
         $display("[TB] FAIL %s tc: got %b expected %b", name, bus.tc, e.tc);
      end
      checks++;
      if (bus.busy !== e.busy) begin
         errors++;
         $display("[TB] FAIL %s busy: got %b expected %b", name, bus.busy, e.busy);
      end
   endtask

   task automatic step(input logic ld, input logic [WIDTH-1:0] dv, input logic ev, input logic mv, input string name);
      applyStimulus(ld, dv, ev, mv);
      checkOutput(name);
   endtask

   task automatic checkIdleZero(input string name);
      checks++;
      if (bus.q !== '0 || bus.tc !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s: got q=%0d tc=%b busy=%b expected q=0 tc=0 busy=0",
                  name, bus.q, bus.tc, bus.busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.load = 1'b1; bus.d = 3'd5; bus.en = 1'b1; bus.mode = 1'b0;
      #1 checkIdleZero("reset_start");
      #10 checkIdleZero("reset_across_negedge");
      #1 rst = 1'b0;
      bus.load = 1'b0; bus.en = 1'b0;
      modelReset();
      step(1'b0, 3'd0, 1'b1, 1'b0, "idle_hold");
   endtask

   task automatic test_oneshot();
      logic [WIDTH-1:0] expQ [7];
      expQ = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
      for (int i = 0; i < 7; i++) begin
         step((i == 0), 3'd5, 1'b1, 1'b0, "oneshot");
         checks++;
         if (bus.q !== expQ[i] || bus.tc !== (i == 5) || bus.busy !== (i < 6)) begin
            errors++;
            $display("[TB] FAIL oneshot_table[%0d]: got q=%0d tc=%b busy=%b expected q=%0d tc=%b busy=%b",
                     i, bus.q, bus.tc, bus.busy, expQ[i], (i == 5), (i < 6));
         end
      end
      step(1'b0, 3'd0, 1'b1, 1'b1, "done_holds");
   endtask

   task automatic test_reload();
      int tcCount = 0;
      step(1'b1, 3'd3, 1'b1, 1'b1, "reload_load");
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 3'd0, 1'b1, 1'b1, "reload_count");
         if (bus.tc === 1'b1) tcCount++;
      end
      checks++;
      if (tcCount != 3) begin
         errors++;
         $display("[TB] FAIL reload_tc_pulses: got %0d expected 3", tcCount);
      end
   endtask

   task automatic test_en_gating();
      step(1'b1, 3'd6, 1'b0, 1'b0, "gate_load");
      repeat (2) step(1'b0, 3'd0, 1'b1, 1'b0, "gate_count");
      repeat (3) step(1'b0, 3'd0, 1'b0, 1'b0, "gate_hold");
      repeat (5) step(1'b0, 3'd0, 1'b1, 1'b0, "gate_resume");
   endtask

   task automatic test_load_edges();
      step(1'b1, 3'd0, 1'b1, 1'b1, "load_zero");
      repeat (3) step(1'b0, 3'd0, 1'b1, 1'b1, "zero_done");
      step(1'b1, 3'd5, 1'b0, 1'b0, "load_five");
      repeat (3) step(1'b0, 3'd0, 1'b1, 1'b0, "count_to_two");
      step(1'b1, 3'd7, 1'b1, 1'b0, "reload_mid_run");
      repeat (2) step(1'b0, 3'd0, 1'b1, 1'b0, "restart_count");
   endtask

   task automatic test_async_reset();
      step(1'b1, 3'd6, 1'b1, 1'b0, "ar_load");
      repeat (3) step(1'b0, 3'd0, 1'b1, 1'b0, "ar_count");
      @(posedge clk);
      #2 rst = 1'b1;
      #1 checkIdleZero("async_reset_between_edges");
      #1 rst = 1'b0;
      modelReset();
      step(1'b0, 3'd0, 1'b1, 1'b1, "after_async_reset");
   endtask

   task automatic test_back_to_back();
      step(1'b1, 3'd2, 1'b1, 1'b1, "b2b_load");
      repeat (2) step(1'b0, 3'd0, 1'b1, 1'b1, "b2b_count");
      step(1'b0, 3'd0, 1'b1, 1'b0, "mode_change_stop");
      step(1'b1, 3'd1, 1'b1, 1'b0, "load_from_done");
      step(1'b1, 3'd4, 1'b1, 1'b0, "load_back_to_back");
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 3'd0, $urandom_range(0, 1), $urandom_range(0, 1), "random_run");
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      modelReset();
      test_reset();
      test_oneshot();
      test_reload();
      test_en_gating();
      test_load_edges();
      test_async_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
